// File: rtl/sram_1p_arbiter.sv
// Write-priority arbiter sharing one single-port SRAM between a read and a write requester.
// Define SRAM_ARB_INIT_EN to zero-fill the SRAM after reset before granting any request.
module sram_1p_arbiter #(
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MASK_W       = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [MASK_W-1:0] wr_req_mask,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data,
  output logic [MASK_W-1:0] sram_w_mask,
  output logic              init_done
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

`ifdef SRAM_ARB_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_init_ptr, w_init_ptr_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_cnt_nxt;
  logic              r_rd_resp_valid;
  logic              w_rd_grant, w_wr_grant;

  // Grant decision and SRAM port drive; nothing is granted while reset is held.
  always_comb begin
    w_state_nxt      = r_state;
    w_init_ptr_nxt   = r_init_ptr;
    w_starve_cnt_nxt = r_starve_cnt;
    w_rd_grant       = 1'b0;
    w_wr_grant       = 1'b0;
    sram_w_en        = 1'b0;
    sram_w_addr      = wr_req_addr;
    sram_w_data      = wr_req_data;
    sram_w_mask      = wr_req_mask;
    if (!reset) begin
      case (r_state)
        ST_INIT: begin
          sram_w_en      = 1'b1;
          sram_w_addr    = r_init_ptr;
          sram_w_data    = '0;
          sram_w_mask    = '1;
          w_init_ptr_nxt = r_init_ptr + ADDR_W'(1);
          if (r_init_ptr == LAST_ADDR) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_req_valid && (r_starve_cnt == STARVE_MAX)) begin
            w_rd_grant = 1'b1;
          end else if (wr_req_valid) begin
            w_wr_grant = 1'b1;
          end else if (rd_req_valid) begin
            w_rd_grant = 1'b1;
          end
          sram_w_en = w_wr_grant;
          // Count writes that overtook a waiting read; saturate at the limit.
          if (w_rd_grant || !rd_req_valid) begin
            w_starve_cnt_nxt = '0;
          end else if (w_wr_grant && (r_starve_cnt != STARVE_MAX)) begin
            w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= RESET_STATE;
      r_init_ptr      <= '0;
      r_starve_cnt    <= '0;
      r_rd_resp_valid <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_init_ptr      <= w_init_ptr_nxt;
      r_starve_cnt    <= w_starve_cnt_nxt;
      r_rd_resp_valid <= w_rd_grant;
    end
  end

`ifdef SRAM_ARB_INIT_EN
  logic r_init_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_init_done <= 1'b0;
    end else if ((r_state == ST_INIT) && (w_state_nxt == ST_RUN)) begin
      r_init_done <= 1'b1;
    end
  end

  assign init_done = r_init_done;
`else
  assign init_done = 1'b1;
`endif

  assign rd_req_ready  = w_rd_grant;
  assign wr_req_ready  = w_wr_grant;
  assign sram_r_addr   = rd_req_addr;
  assign rd_resp_valid = r_rd_resp_valid;
  // SRAM read data already arrives one cycle after the address, aligned with the valid pulse.
  assign rd_resp_data  = sram_r_data;

endmodule

// File: tb/tb_sram_1p_arbiter.sv
// Directed bench for sram_1p_arbiter with a masked, one-cycle-latency SRAM model.
// Follows the SRAM_ARB_INIT_EN setting of the build for the reset/init portions.
`timescale 1ns/1ps
module tb_sram_1p_arbiter;

  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned MASK_W       = 4;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned DEPTH        = 1 << ADDR_W;
  localparam int unsigned SLICE        = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic [MASK_W-1:0] wr_req_mask;
  logic [ADDR_W-1:0] sram_r_addr;
  logic [DATA_W-1:0] sram_r_data;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_w_addr;
  logic [DATA_W-1:0] sram_w_data;
  logic [MASK_W-1:0] sram_w_mask;
  logic              init_done;

  logic [DATA_W-1:0] mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  sram_1p_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
    .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data),
    .sram_w_mask(sram_w_mask), .init_done(init_done)
  );

  // SRAM model: masked write, registered read; preset to 0xEE so a zero-fill is visible.
  always @(posedge clock) begin : sram_model
    logic [DATA_W-1:0] v;
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'hEE;
    end else if (sram_w_en) begin
      v = mem[sram_w_addr];
      for (int b = 0; b < int'(MASK_W); b++)
        if (sram_w_mask[b]) v[b*SLICE +: SLICE] = sram_w_data[b*SLICE +: SLICE];
      mem[sram_w_addr] <= v;
    end
    sram_r_data <= mem[sram_r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [MASK_W-1:0] m);
    wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d; wr_req_mask = m;
    rd_req_valid = 1'b0;
    #1;
    chk($sformatf("wr_ready@%0h", a), wr_req_ready, 1);
    chk($sformatf("wr_rd_ready@%0h", a), rd_req_ready, 0);
    chk($sformatf("wr_wen@%0h", a), sram_w_en, 1);
    chk($sformatf("wr_waddr@%0h", a), sram_w_addr, a);
    chk($sformatf("wr_wdata@%0h", a), sram_w_data, d);
    chk($sformatf("wr_wmask@%0h", a), sram_w_mask, m);
    cyc;
    wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    rd_req_valid = 1'b1; rd_req_addr = a; wr_req_valid = 1'b0;
    #1;
    chk($sformatf("rd_ready@%0h", a), rd_req_ready, 1);
    chk($sformatf("rd_wr_ready@%0h", a), wr_req_ready, 0);
    chk($sformatf("rd_wen@%0h", a), sram_w_en, 0);
    chk($sformatf("rd_raddr@%0h", a), sram_r_addr, a);
    cyc;
    rd_req_valid = 1'b0;
    #1;
    chk($sformatf("rd_resp_valid@%0h", a), rd_resp_valid, 1);
    chk($sformatf("rd_resp_data@%0h", a), rd_resp_data, exp);
    cyc;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    string rv;
    string gr;
    reset = 1'b1;
    rd_req_valid = 1'b0; rd_req_addr = '0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0;
    repeat (2) @(posedge clock);
    #1;

    // Requests present during reset must not be granted.
    rd_req_valid = 1'b1; rd_req_addr = 7'h10;
    wr_req_valid = 1'b1; wr_req_addr = 7'h22; wr_req_data = 8'h5A; wr_req_mask = 4'hF;
    #1;
    chk("rst_rd_ready", rd_req_ready, 0);
    chk("rst_wr_ready", wr_req_ready, 0);
    chk("rst_wen", sram_w_en, 0);
    chk("rst_resp_valid", rd_resp_valid, 0);
`ifdef SRAM_ARB_INIT_EN
    chk("rst_init_done", init_done, 0);
    cyc;
    reset = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      #1;
      chk($sformatf("init_wen[%0d]", i), sram_w_en, 1);
      chk($sformatf("init_waddr[%0d]", i), sram_w_addr, i);
      chk($sformatf("init_wdata[%0d]", i), sram_w_data, 0);
      chk($sformatf("init_wmask[%0d]", i), sram_w_mask, 4'hF);
      chk($sformatf("init_rd_ready[%0d]", i), rd_req_ready, 0);
      chk($sformatf("init_wr_ready[%0d]", i), wr_req_ready, 0);
      chk($sformatf("init_done[%0d]", i), init_done, 0);
      cyc;
    end
    #1;
    chk("init_done_128", init_done, 1);
    chk("held_wr_granted", wr_req_ready, 1);
    chk("held_rd_waits", rd_req_ready, 0);
    cyc;
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    do_read(7'h7F, 8'h00);
    do_read(7'h22, 8'h5A);
`else
    chk("rst_init_done", init_done, 1);
    wr_req_valid = 1'b0;
    cyc;
    reset = 1'b0;
    #1;
    chk("first_rd_ready", rd_req_ready, 1);
    chk("first_wr_ready", wr_req_ready, 0);
    chk("first_wen", sram_w_en, 0);
    chk("first_raddr", sram_r_addr, 7'h10);
    chk("first_init_done", init_done, 1);
    cyc;
    rd_req_valid = 1'b0;
    #1;
    chk("first_resp_valid", rd_resp_valid, 1);
    chk("run_init_done", init_done, 1);
    cyc;
`endif

    // Write then immediate read of the same entry, then a masked update.
    do_write(7'h05, 8'hA5, 4'hF);
    do_read(7'h05, 8'hA5);
    #1;
    chk("resp_pulse_end", rd_resp_valid, 0);
    cyc;
    do_write(7'h05, 8'hFF, 4'h3);
    do_read(7'h05, 8'hAF);

    // Idle: write port mirrors the request inputs with the enable low.
    wr_req_addr = 7'h33; wr_req_data = 8'h3C; wr_req_mask = 4'h6; rd_req_addr = 7'h44;
    #1;
    chk("idle_wen", sram_w_en, 0);
    chk("idle_waddr", sram_w_addr, 7'h33);
    chk("idle_wdata", sram_w_data, 8'h3C);
    chk("idle_wmask", sram_w_mask, 4'h6);
    chk("idle_raddr", sram_r_addr, 7'h44);
    chk("idle_rd_ready", rd_req_ready, 0);
    chk("idle_wr_ready", wr_req_ready, 0);
    chk("idle_resp_valid", rd_resp_valid, 0);
    cyc;

    // Contention: starvation guard, then counter clear when the read drops out.
    rv = "1111111111111011111";
    gr = "WWWWRWWWWRWWWWWWWWR";
    rd_req_addr = 7'h05; wr_req_addr = 7'h40; wr_req_data = 8'h11; wr_req_mask = 4'hF;
    for (int i = 0; i < rv.len(); i++) begin
      rd_req_valid = (rv[i] == "1");
      wr_req_valid = 1'b1;
      #1;
      chk($sformatf("arb_rd_ready[%0d]", i), rd_req_ready, gr[i] == "R");
      chk($sformatf("arb_wr_ready[%0d]", i), wr_req_ready, gr[i] == "W");
      chk($sformatf("arb_resp_valid[%0d]", i), rd_resp_valid, (i > 0) && (gr[i-1] == "R"));
      if ((i > 0) && (gr[i-1] == "R"))
        chk($sformatf("arb_resp_data[%0d]", i), rd_resp_data, 8'hAF);
      cyc;
    end
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    #1;
    chk("arb_last_resp_valid", rd_resp_valid, 1);
    chk("arb_last_resp_data", rd_resp_data, 8'hAF);
    cyc;
    do_read(7'h40, 8'h11);

    // Reset while a read response is being presented.
    rd_req_valid = 1'b1; rd_req_addr = 7'h05;
    #1;
    chk("pre_rst_rd_ready", rd_req_ready, 1);
    cyc;
    #1;
    chk("pre_rst_resp_valid", rd_resp_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", rd_resp_valid, 0);
    chk("mid_rst_rd_ready", rd_req_ready, 0);
    chk("mid_rst_wen", sram_w_en, 0);
`ifdef SRAM_ARB_INIT_EN
    chk("mid_rst_init_done", init_done, 0);
`else
    chk("mid_rst_init_done", init_done, 1);
`endif
    cyc;
    cyc;
    reset = 1'b0; rd_req_valid = 1'b0;
    #1;
    chk("post_rst_resp_valid", rd_resp_valid, 0);
`ifdef SRAM_ARB_INIT_EN
    chk("restart_wen", sram_w_en, 1);
    chk("restart_waddr0", sram_w_addr, 7'h00);
    chk("restart_init_done", init_done, 0);
    cyc;
    #1;
    chk("restart_waddr1", sram_w_addr, 7'h01);
    chk("restart_wen1", sram_w_en, 1);
`else
    chk("post_rst_wen", sram_w_en, 0);
    chk("post_rst_init_done", init_done, 1);
    cyc;
    do_write(7'h12, 8'h77, 4'hF);
    do_read(7'h12, 8'h77);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_1p_arbiter.md
Name: sram_1p_arbiter

Overview:
Controller that shares one single-port SRAM wrapper between a read requester and a write requester. The SRAM wrapper has separate read and write address/data ports, and a write overrides a read. The block sequences a post-reset zero-fill sweep, then grants at most one access per cycle under write-priority arbitration with a starvation guard for reads. It sits between pipeline-side requesters and the SRAM template instance.

Parameters:
ADDR_W, 7, SRAM address width; depth is 2^ADDR_W entries
DATA_W, 8, SRAM data width
MASK_W, 4, write-mask width; each mask bit covers DATA_W/MASK_W data bits
STARVE_LIMIT, 4, consecutive write grants allowed while a read waits before the read is forced through

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
rd_req_valid  in  1  read request present
rd_req_ready  out  1  read request granted this cycle
rd_req_addr  in  ADDR_W  read address
rd_resp_valid  out  1  read data valid; one-cycle pulse
rd_resp_data  out  DATA_W  read data
wr_req_valid  in  1  write request present
wr_req_ready  out  1  write request granted this cycle
wr_req_addr  in  ADDR_W  write address
wr_req_data  in  DATA_W  write data
wr_req_mask  in  MASK_W  write mask
sram_r_addr  out  ADDR_W  SRAM read address
sram_r_data  in  DATA_W  SRAM read data, valid the cycle after the address is presented
sram_w_en  out  1  SRAM write enable
sram_w_addr  out  ADDR_W  SRAM write address
sram_w_data  out  DATA_W  SRAM write data
sram_w_mask  out  MASK_W  SRAM write mask
init_done  out  1  zero-fill sweep complete

Behaviour:
- Reset (asynchronous):
  - state=INIT, init_ptr=0, starve_cnt=0.
  - rd_resp_valid=0, init_done=0.
  - rd_req_ready=0, wr_req_ready=0, sram_w_en=0.
- State INIT:
  - sram_w_en=1, sram_w_addr=init_ptr, sram_w_data=0, sram_w_mask=all ones.
  - init_ptr increments each cycle.
  - rd_req_ready=0 and wr_req_ready=0; requests are held, not dropped.
  - When init_ptr=2^ADDR_W-1 is written, the next state is RUN and the init_done register is set to 1.
  - The sweep takes exactly 2^ADDR_W cycles (128 at default).
- State RUN: each cycle, the grant decision is combinational from the valid inputs and starve_cnt.
  - Force-read case: if rd_req_valid and starve_cnt==STARVE_LIMIT, grant the read.
  - Otherwise, if wr_req_valid, grant the write.
  - Otherwise, if rd_req_valid, grant the read.
  - Otherwise, grant nothing.
- Write grant:
  - wr_req_ready=1, sram_w_en=1.
  - sram_w_addr/data/mask are taken from wr_req_*.
- Read grant:
  - rd_req_ready=1, sram_w_en=0, sram_r_addr=rd_req_addr.
  - Next cycle: rd_resp_valid=1 and rd_resp_data=sram_r_data (latency 1).
  - There is no response backpressure; the consumer must accept.
- Idle outputs: when no write is granted, sram_w_en=0 and sram_w_addr/data/mask still mirror wr_req_*. sram_r_addr always mirrors rd_req_addr.
- starve_cnt:
  - Increments when a write is granted while rd_req_valid=1, saturating at STARVE_LIMIT.
  - Clears when a read is granted.
  - Clears when rd_req_valid=0.
- Back-to-back access:
  - A read granted the cycle after a write to the same address returns the new data.
  - A read and a write in the same cycle never occur.
- Reset asserted mid-operation:
  - A pending rd_resp_valid is cleared immediately and the response is lost.
  - The FSM restarts the INIT sweep from address 0.
- Ready signals depend on valid signals combinationally. Requesters must not make valid depend on ready.

Optional Feature:
SRAM_ARB_INIT_EN
- Defined: INIT sweep as described; init_done resets to 0.
- Undefined:
  - No INIT state; the FSM resets directly into RUN.
  - init_done is tied to 1, including during reset.
  - Requests can be granted in the first cycle after reset deasserts.
  - SRAM contents are undefined until written.

Test Plan:
1. Release reset with no requests (macro on) -> 128 consecutive cycles of sram_w_en=1, addr 0x00..0x7F, data 0x00, mask 0xF; init_done=1 from cycle 128; readies 0 throughout.
2. After init, write addr 0x05 data 0xA5 mask 0xF, then read 0x05 the next cycle -> rd_req_ready=1 on the read cycle; rd_resp_valid=1 with rd_resp_data=0xA5 one cycle later.
3. Entry 0x05=0xA5, write data 0xFF mask 0x3 -> only the low 4 bits change; a subsequent read returns 0xAF.
4. rd_req_valid and wr_req_valid both held high for 10 cycles with STARVE_LIMIT=4 -> grant sequence W,W,W,W,R,W,W,W,W,R; rd_resp_valid pulses in cycles 5 and 10.
5. Read granted, then reset asserted before the next edge -> rd_resp_valid=0 immediately; after release, the sweep restarts at address 0x00.
6. Macro undefined, reset released with a read to 0x10 pending -> init_done=1 throughout; read granted in the first cycle after reset and rd_resp_valid the cycle after.
